bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 13 +
 rtl/tag_fifo.sv | 61 ++++++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter and its read-tag FIFO.
package bus_pkg;

  // Index of a requesting master; also used as the tag stored per outstanding read.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  // Default number of outstanding reads tracked.
  localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of master tags for outstanding reads.
// Pushes while full and pops while empty are ignored.
module tag_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  master_e       push_tag_i,
  input  logic          pop_i,
  output master_e       head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  master_e       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with in-order read-response routing.
// Request and response paths are purely combinational; only the grant
// history, the tag FIFO and the sticky protocol error are registered.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  // master 0
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,
  // master 1
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,
  // slave
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_byte_enable,
  output logic        s_write_req,
  output logic        s_read_req,
  input  logic [31:0] s_read_data,
  input  logic        s_read_data_valid,
  output logic        protocol_error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  master_e       last_grant_q, last_grant_d;
  logic          perr_q, perr_d;
  master_e       winner;
  logic          has_winner, accept;
  logic          elig0, elig1;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  master_e       fifo_head;
  logic [CW-1:0] fifo_count;

  // A full FIFO blocks reads regardless of a same-cycle pop.
  assign elig0 = (m0_write_req | m0_read_req) & ~(m0_read_req & fifo_full);
  assign elig1 = (m1_write_req | m1_read_req) & ~(m1_read_req & fifo_full);

  // Winner selection: sole eligible master, else the one not granted last.
  always_comb begin
    has_winner = 1'b0;
    winner     = M0;
    if (elig0 && elig1) begin
      has_winner = 1'b1;
      winner     = (last_grant_q == M0) ? M1 : M0;
    end else if (elig0) begin
      has_winner = 1'b1;
      winner     = M0;
    end else if (elig1) begin
      has_winner = 1'b1;
      winner     = M1;
    end
  end

  // Forward the winner's request to the slave; idle bus drives zeros.
  always_comb begin
    s_addr        = '0;
    s_write_data  = '0;
    s_byte_enable = '0;
    s_write_req   = 1'b0;
    s_read_req    = 1'b0;
    if (has_winner) begin
      if (winner == M0) begin
        s_addr        = m0_addr;
        s_write_data  = m0_write_data;
        s_byte_enable = m0_byte_enable;
        s_write_req   = m0_write_req;
        s_read_req    = m0_read_req;
      end else begin
        s_addr        = m1_addr;
        s_write_data  = m1_write_data;
        s_byte_enable = m1_byte_enable;
        s_write_req   = m1_write_req;
        s_read_req    = m1_read_req;
      end
    end
  end

  assign accept   = s_ready & has_winner;
  assign m0_ready = accept & (winner == M0);
  assign m1_ready = accept & (winner == M1);

  // s_read_req already reflects the winner's read request.
  assign fifo_push = accept & s_read_req;
  assign fifo_pop  = s_read_data_valid & ~fifo_empty;

  // Route a response to the master at the head of the tag FIFO.
  always_comb begin
    m0_read_data       = '0;
    m0_read_data_valid = 1'b0;
    m1_read_data       = '0;
    m1_read_data_valid = 1'b0;
    if (fifo_pop) begin
      if (fifo_head == M0) begin
        m0_read_data       = s_read_data;
        m0_read_data_valid = 1'b1;
      end else begin
        m1_read_data       = s_read_data;
        m1_read_data_valid = 1'b1;
      end
    end
  end

  // Next grant history and sticky error on an unsolicited response.
  always_comb begin
    last_grant_d = accept ? winner : last_grant_q;
    perr_d       = perr_q | (s_read_data_valid & (fifo_count == '0));
  end

  // Grant history resets to M1 so M0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= M1;
      perr_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      perr_q       <= perr_d;
    end
  end

  assign protocol_error = perr_q;

  tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (fifo_push),
    .push_tag_i(winner),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule
